// File: rtl/nibble_serial_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nibble_serial_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index width for a nibble counter; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nibble_add4.sv
// Combinational 4-bit ripple-carry adder slice.
module nibble_add4 (
    input  logic       cin,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] sum,
    output logic       cout
);

    logic c;

    always_comb begin
        c   = cin;
        sum = '0;
        for (int i = 0; i < 4; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that feeds one 4-bit slice a nibble per cycle, LSB first.
// Optional subtract mode (sub port) is enabled by defining NIBBLE_SERIAL_SUB_EN.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | one nibble through the slice per cycle
// DONE  | result held with out_valid=1 until out_ready
module nibble_serial_adder
    import nibble_serial_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             carryIn,
`ifdef NIBBLE_SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carryOut,
    output logic             busy
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = idx_w(NIBBLES);

    state_t             state;
    logic [IDX_W-1:0]   nib_idx;
    logic               carry_q;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [NIBBLE_W-1:0] slice_sum;
    logic               slice_cout;

    assign in_ready = !rst && (state == IDLE);
    assign busy     = (state == RUN) || (state == DONE);

    // The only path between nibbles is carry_q, so the slice never chains combinationally.
    nibble_add4 u_slice (
        .cin  (carry_q),
        .a    (op_a[{nib_idx, 2'b00} +: NIBBLE_W]),
        .b    (op_b[{nib_idx, 2'b00} +: NIBBLE_W]),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            nib_idx   <= '0;
            carry_q   <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            out       <= '0;
            carryOut  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        op_a <= in1;
`ifdef NIBBLE_SERIAL_SUB_EN
                        op_b    <= sub ? ~in2 : in2;
                        carry_q <= sub ? 1'b1 : carryIn;
`else
                        op_b    <= in2;
                        carry_q <= carryIn;
`endif
                        out      <= '0;
                        carryOut <= 1'b0;
                        nib_idx  <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    out[{nib_idx, 2'b00} +: NIBBLE_W] <= slice_sum;
                    carry_q <= slice_cout;
                    if (nib_idx == IDX_W'(NIBBLES - 1)) begin
                        carryOut  <= slice_cout;
                        out_valid <= 1'b1;
                        nib_idx   <= '0;
                        state     <= DONE;
                    end else begin
                        nib_idx <= nib_idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
